fetch_queue: RTL and testbench

- Instruction fetch queue between the fetch stage and decode.
- Captures each fetched {PC, instruction} pair and buffers up to DEPTH entries.
- Presents entries to decode in order over a valid/ready handshake.
- Discards all buffered entries when a taken branch redirects fetch.

---
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer of {pc, instr} pairs with flush.
// Define FETCHQ_BYPASS_EN to pass a push straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_F,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [PC_W-1:0]              push_pc,
  input  logic [INSTR_W-1:0]           push_instr,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [PC_W-1:0]              pop_pc,
  output logic [INSTR_W-1:0]           pop_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               empty;
  logic               full;
  logic               bypass_fire;
  logic               push_fire;
  logic               pop_fire;
  entry_t             head;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Handshake and head selection
  always_comb begin
    push_ready  = ~full & ~reset;
    pop_valid   = ~empty & ~flush_F & ~reset;
    head        = mem[rd_ptr];
    bypass_fire = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if (empty && !flush_F && !reset) begin
      pop_valid   = push_valid;
      head        = '{pc: push_pc, instr: push_instr};
      bypass_fire = push_valid & pop_ready;
    end
`endif
    push_fire = push_valid & push_ready & ~flush_F & ~bypass_fire;
    pop_fire  = pop_valid & pop_ready & ~empty;
    pop_pc    = head.pc;
    pop_instr = head.instr;
  end

  // Pointers and occupancy; flush empties the queue and drops any push in that cycle
  always_ff @(posedge clk) begin
    if (reset || flush_F) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries between rd_ptr and wr_ptr are ever observed
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random traffic with flushes and resets.
// Expectations follow FETCHQ_BYPASS_EN when it is defined.
module tb_fetch_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush_F = 1'b0;
  logic               push_valid = 1'b0;
  logic               push_ready;
  logic [PC_W-1:0]    push_pc = '0;
  logic [INSTR_W-1:0] push_instr = '0;
  logic               pop_valid;
  logic               pop_ready = 1'b0;
  logic [PC_W-1:0]    pop_pc;
  logic [INSTR_W-1:0] pop_instr;
  logic [CNT_W-1:0]   count;

  int n_checks = 0;
  int n_errors = 0;
  logic [PC_W+INSTR_W-1:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_F    (flush_F),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive after the edge, sample at the falling edge, then advance the scoreboard
  task automatic step(input logic rst, input logic fl, input logic pv, input logic pr,
                      input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    logic byp;
    logic exp_pv;
    logic accept;
    @(posedge clk); #1;
    reset = rst; flush_F = fl; push_valid = pv; pop_ready = pr;
    push_pc = pc; push_instr = ins;
    @(negedge clk);
    if (rst) begin
      check("rst_push_ready", 128'(push_ready), 128'(0));
      check("rst_pop_valid", 128'(pop_valid), 128'(0));
      sb.delete();
    end else begin
      byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      byp = (sb.size() == 0) && pv && !fl;
`endif
      exp_pv = !fl && (sb.size() != 0 || byp);
      check("count", 128'(count), 128'(sb.size()));
      check("push_ready", 128'(push_ready), 128'(sb.size() < DEPTH));
      check("pop_valid", 128'(pop_valid), 128'(exp_pv));
      if (exp_pv)
        check("head", 128'({pop_pc, pop_instr}), byp ? 128'({pc, ins}) : 128'(sb[0]));
      if (fl) begin
        sb.delete();
      end else if (!(byp && pr)) begin
        accept = pv && (sb.size() < DEPTH);
        if (exp_pv && pr) void'(sb.pop_front());
        if (accept) sb.push_back({pc, ins});
      end
    end
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins, input logic pr);
    step(1'b0, 1'b0, 1'b1, pr, pc, ins);
  endtask

  task automatic idle(input logic pr);
    step(1'b0, 1'b0, 1'b0, pr, '0, '0);
  endtask

  initial begin
    // Reset for two cycles, with a push presented that must be ignored
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h99, 32'h99);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h99, 32'h99);

    // Fill to full, then a held fifth push is refused
    for (int i = 0; i < 4; i++) push(64'(i * 4), 32'(8'hA0 + i), 1'b0);
    push(64'h10, 32'hA4, 1'b0);
    push(64'h10, 32'hA4, 1'b0);

    // Drain in order, then empty
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Concurrent push/pop at count=1 with pointer wrap
    push(64'h200, 32'hB0, 1'b0);
    for (int i = 1; i <= 6; i++) push(64'(32'h200 + i * 4), 32'(8'hB0 + i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush mid-stream drops the queue and the push in the flush cycle
    push(64'h20, 32'hC0, 1'b0);
    push(64'h24, 32'hC1, 1'b0);
    push(64'h28, 32'hC2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h2C, 32'hC3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'h2C, 32'hC3);
    idle(1'b0);
    push(64'h100, 32'hC4, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation
    push(64'h30, 32'hD0, 1'b0);
    push(64'h34, 32'hD1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h38, 32'hD2);
    push(64'h40, 32'hD3, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Push into an empty queue with decode ready
    push(64'h50, 32'hE0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           {$urandom, $urandom}, $urandom);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("final_count", 128'(count), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
